s4ga_cfg_seq: RTL and testbench

- Sequencer that sits in front of the S4GA LUT fabric and owns its config stream.
- Stores one full frame of LUT configs (N LUTs) in an internal segment memory, loaded through a simple write port.
- Replays the frame to the fabric's SI_W-bit serial input one segment per clock, with run/step/halt control and frame bookkeeping.
- Drives the fabric's reset so the fabric's internal n/k/seg counters stay aligned with the stream.

---
 rtl/s4ga_cfg_seq.sv | 145 ++++++++++++++
 tb/tb_s4ga_cfg_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/s4ga_cfg_seq.sv
// Config-stream sequencer for the S4GA LUT fabric: holds one frame of LUT
// segments and replays it to the fabric serial input with run/step control.
module s4ga_cfg_seq #(
   parameter  int N         = 16,
   parameter  int K         = 4,
   parameter  int SI_W      = 4,
   parameter  int FCNT_W    = 16,
   localparam int IDX_SEGS  = ($clog2(N) + SI_W - 1) / SI_W,
   localparam int MASK_SEGS = ((2 ** K) + SI_W - 1) / SI_W,
   localparam int LUT_SEGS  = K * IDX_SEGS + MASK_SEGS,
   localparam int DEPTH     = N * LUT_SEGS,
   localparam int A_W       = $clog2(DEPTH),
   localparam int LI_W      = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [A_W-1:0]    cfg_addr,
   input  logic [SI_W-1:0]   cfg_wdata,
   input  logic              run,
   input  logic              step,
   output logic              fab_rst,
   output logic [SI_W-1:0]   fab_si,
   output logic              busy,
   output logic [LI_W-1:0]   lut_idx,
   output logic              lut_upd,
   output logic              frame_done,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              cfg_err
);

   localparam int SUB_W = (LUT_SEGS > 1) ? $clog2(LUT_SEGS) : 1;
   localparam logic [A_W:0]     L_DEPTH    = (A_W + 1)'(DEPTH);
   localparam logic [A_W-1:0]   L_LAST     = A_W'(DEPTH - 1);
   localparam logic [SUB_W-1:0] L_SUB_LAST = SUB_W'(LUT_SEGS - 1);
   localparam logic [LI_W-1:0]  L_LUT_LAST = LI_W'(N - 1);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [SI_W-1:0]   r_mem [DEPTH];
   logic [A_W-1:0]    r_rd_addr;
   logic [SUB_W-1:0]  r_sub;
   logic              r_one_shot;
   logic              r_fab_rst;
   logic [SI_W-1:0]   r_fab_si;
   logic [LI_W-1:0]   r_lut_idx;
   logic              r_lut_upd;
   logic              r_frame_done;
   logic [FCNT_W-1:0] r_frame_cnt;
   logic              r_cfg_err;

   logic              w_start;
   logic              w_stop;
   logic              w_adv;
   logic [A_W-1:0]    w_seg;
   logic              w_wr_ok;

   // w_seg is the index of the segment that goes onto fab_si at this edge.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_stop      = 1'b0;
      w_seg       = r_rd_addr;
      case (r_state)
         S_IDLE: begin
            if (run || step) begin
               w_state_nxt = S_STREAM;
               w_start     = 1'b1;
               w_seg       = '0;
            end
         end
         S_STREAM: begin
            if (r_frame_done && !(run && !r_one_shot)) begin
               w_state_nxt = S_IDLE;
               w_stop      = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_adv   = w_start || ((r_state == S_STREAM) && !w_stop);
   assign w_wr_ok = cfg_we && (r_state == S_IDLE) && ({1'b0, cfg_addr} < L_DEPTH);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (w_wr_ok) r_mem[cfg_addr] <= cfg_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fab_rst    <= 1'b1;
         r_fab_si     <= '0;
         r_rd_addr    <= '0;
         r_sub        <= '0;
         r_lut_idx    <= '0;
         r_lut_upd    <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= '0;
         r_one_shot   <= 1'b0;
         r_cfg_err    <= 1'b0;
      end else begin
         if (cfg_we && (r_state == S_STREAM)) r_cfg_err <= 1'b1;
         if (w_stop) begin
            r_fab_rst    <= 1'b1;
            r_fab_si     <= '0;
            r_rd_addr    <= '0;
            r_sub        <= '0;
            r_lut_idx    <= '0;
            r_lut_upd    <= 1'b0;
            r_frame_done <= 1'b0;
            r_one_shot   <= 1'b0;
         end else if (w_adv) begin
            r_fab_rst    <= 1'b0;
            r_fab_si     <= r_mem[w_seg];
            r_rd_addr    <= (w_seg == L_LAST) ? '0 : w_seg + 1'b1;
            // r_sub tracks w_seg mod LUT_SEGS; DEPTH is a multiple so it wraps with the frame.
            r_sub        <= (r_sub == L_SUB_LAST) ? '0 : r_sub + 1'b1;
            r_lut_upd    <= (r_sub == L_SUB_LAST);
            if (r_lut_upd)
               r_lut_idx <= (r_lut_idx == L_LUT_LAST) ? '0 : r_lut_idx + 1'b1;
            r_frame_done <= (w_seg == L_LAST);
            if (w_seg == L_LAST) r_frame_cnt <= r_frame_cnt + 1'b1;
            if (w_start)  r_one_shot <= step && !run;
            else if (run) r_one_shot <= 1'b0;
         end
      end
   end

   assign fab_rst    = r_fab_rst;
   assign fab_si     = r_fab_si;
   assign busy       = (r_state == S_STREAM);
   assign lut_idx    = r_lut_idx;
   assign lut_upd    = r_lut_upd;
   assign frame_done = r_frame_done;
   assign frame_cnt  = r_frame_cnt;
   assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_s4ga_cfg_seq.sv
// Directed bench for s4ga_cfg_seq: step/run frames, halt timing, busy writes,
// mid-stream reset, checked segment by segment against a memory model.
module tb_s4ga_cfg_seq;
   localparam int DEPTH = 128;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_we = 1'b0;
   logic [6:0] cfg_addr = '0;
   logic [3:0] cfg_wdata = '0;
   logic       run = 1'b0;
   logic       step = 1'b0;
   logic       fab_rst;
   logic [3:0] fab_si;
   logic       busy;
   logic [3:0] lut_idx;
   logic       lut_upd;
   logic       frame_done;
   logic [15:0] frame_cnt;
   logic       cfg_err;

   always #5 clk = ~clk;

   s4ga_cfg_seq dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .run(run), .step(step), .fab_rst(fab_rst),
      .fab_si(fab_si), .busy(busy), .lut_idx(lut_idx), .lut_upd(lut_upd),
      .frame_done(frame_done), .frame_cnt(frame_cnt), .cfg_err(cfg_err)
   );

   int         n_checks = 0;
   int         n_fail = 0;
   logic [3:0] exp_mem [DEPTH];
   logic [3:0] exp_q [$];
   int         exp_fcnt = 0;
   logic       exp_err = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_checks++;
      if (obs !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic idle_write(input int addr, input logic [3:0] data);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 7'(addr); cfg_wdata = data;
      exp_mem[addr] = data;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Starts a stream and checks n_seg consecutive segments; the *_at
   // arguments schedule control events while segment i is on fab_si.
   task automatic run_stream(input bit use_run, input int n_seg, input int run_on_at,
                             input int run_off_at, input int step_at, input int wr_at,
                             input int rst_at);
      bit did_rst = 1'b0;
      for (int i = 0; i < n_seg; i++) exp_q.push_back(exp_mem[i % DEPTH]);
      @(negedge clk);
      if (use_run) run = 1'b1; else step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      for (int i = 0; i < n_seg; i++) begin
         int seg;
         logic [3:0] want_si;
         seg = i % DEPTH;
         want_si = exp_q.pop_front();
         if (seg == DEPTH - 1) exp_fcnt++;
         check_val($sformatf("fab_si[%0d]", i), 32'(fab_si), 32'(want_si));
         check_val($sformatf("fab_rst[%0d]", i), 32'(fab_rst), 32'd0);
         check_val($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
         check_val($sformatf("lut_idx[%0d]", i), 32'(lut_idx), 32'(seg / 8));
         check_val($sformatf("lut_upd[%0d]", i), 32'(lut_upd), 32'(seg % 8 == 7));
         check_val($sformatf("frame_done[%0d]", i), 32'(frame_done), 32'(seg == DEPTH - 1));
         check_val($sformatf("frame_cnt[%0d]", i), 32'(frame_cnt), 32'(exp_fcnt & 16'hffff));
         check_val($sformatf("cfg_err[%0d]", i), 32'(cfg_err), 32'(exp_err));
         step   = (i == step_at);
         cfg_we = (i == wr_at);
         cfg_addr = 7'd5; cfg_wdata = 4'h3;
         if (i == wr_at) exp_err = 1'b1;
         if (i == run_on_at) run = 1'b1;
         if (i == run_off_at) run = 1'b0;
         if (i == rst_at) begin rst = 1'b1; did_rst = 1'b1; end
         @(negedge clk);
         if (did_rst) break;
      end
      step = 1'b0; cfg_we = 1'b0; run = 1'b0;
      if (did_rst) begin
         rst = 1'b0;
         exp_fcnt = 0;
         exp_err = 1'b0;
         exp_q.delete();
      end
      check_val("end_fab_rst", 32'(fab_rst), 32'd1);
      check_val("end_fab_si", 32'(fab_si), 32'd0);
      check_val("end_busy", 32'(busy), 32'd0);
      check_val("end_lut_upd", 32'(lut_upd), 32'd0);
      check_val("end_frame_done", 32'(frame_done), 32'd0);
      check_val("end_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt & 16'hffff));
      check_val("end_cfg_err", 32'(cfg_err), 32'(exp_err));
      @(negedge clk);
      check_val("idle_hold_busy", 32'(busy), 32'd0);
      check_val("idle_hold_fab_rst", 32'(fab_rst), 32'd1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_val("rst_fab_rst", 32'(fab_rst), 32'd1);
      check_val("rst_fab_si", 32'(fab_si), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_lut_idx", 32'(lut_idx), 32'd0);
      check_val("rst_lut_upd", 32'(lut_upd), 32'd0);
      check_val("rst_frame_done", 32'(frame_done), 32'd0);
      check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check_val("rst_cfg_err", 32'(cfg_err), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < DEPTH; i++) idle_write(i, 4'(i % 16));
      check_val("load_cfg_err", 32'(cfg_err), 32'd0);

      // single step frame
      run_stream(1'b0, 128, -1, -1, -1, -1, -1);
      // three continuous frames, run dropped inside the third
      run_stream(1'b1, 384, -1, 300, -1, -1, -1);
      // run dropped at segment 40 of frame 2
      run_stream(1'b1, 256, -1, 168, -1, -1, -1);
      // step while busy ignored; run rising converts step frame to continuous
      run_stream(1'b0, 256, 50, 140, 20, -1, -1);

      idle_write(5, 4'hA);
      check_val("idle_wr_cfg_err", 32'(cfg_err), 32'd0);
      // busy write to addr 5 must be dropped and flag cfg_err
      run_stream(1'b0, 128, -1, -1, -1, 10, -1);
      run_stream(1'b0, 128, -1, -1, -1, -1, -1);

      // reset mid-stream, then a clean restart from segment 0
      run_stream(1'b0, 128, -1, -1, -1, -1, 70);
      run_stream(1'b0, 128, -1, -1, -1, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
